axi_rw_bridge: RTL and testbench

Single-outstanding bridge between the core's internal memory-request port and its AXI4 master port. It accepts one load or store from the core's memory arbiter and issues it as a single-beat AXI4 transaction. For loads it returns LSB-aligned read data; for stores it returns the write response. It drives the core's external AXI4 master interface directly, with no further buffering.

---
 rtl/axi_rw_bridge.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi_rw_bridge.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rw_bridge.sv
// Single-outstanding bridge from the core memory-request port to an AXI4 master.
// Each load or store becomes one single-beat AXI4 transaction; loads return LSB-aligned data.
module axi_rw_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // core request port
  input  logic                        rw_valid_i,
  output logic                        rw_ready_o,
  input  logic                        rw_we_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   rw_addr_i,
  input  logic [1:0]                  rw_size_i,
  input  logic [63:0]                 rw_wdata_i,
  output logic                        rw_resp_valid_o,
  output logic [63:0]                 rw_rdata_o,
  output logic [1:0]                  rw_resp_o,
  // AW
  output logic [AXI_ID_WIDTH-1:0]     axi_aw_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_o,
  output logic [7:0]                  axi_aw_len_o,
  output logic [2:0]                  axi_aw_size_o,
  output logic [1:0]                  axi_aw_burst_o,
  output logic                        axi_aw_lock_o,
  output logic [3:0]                  axi_aw_cache_o,
  output logic [2:0]                  axi_aw_prot_o,
  output logic [3:0]                  axi_aw_qos_o,
  output logic [3:0]                  axi_aw_region_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_aw_user_o,
  output logic                        axi_aw_valid_o,
  input  logic                        axi_aw_ready_i,
  // W
  output logic [AXI_DATA_WIDTH-1:0]   axi_w_data_o,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_o,
  output logic                        axi_w_last_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_w_user_o,
  output logic                        axi_w_valid_o,
  input  logic                        axi_w_ready_i,
  // B
  output logic                        axi_b_ready_o,
  input  logic                        axi_b_valid_i,
  input  logic [1:0]                  axi_b_resp_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_b_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_b_user_i,
  // AR
  output logic [AXI_ID_WIDTH-1:0]     axi_ar_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_o,
  output logic [7:0]                  axi_ar_len_o,
  output logic [2:0]                  axi_ar_size_o,
  output logic [1:0]                  axi_ar_burst_o,
  output logic                        axi_ar_lock_o,
  output logic [3:0]                  axi_ar_cache_o,
  output logic [2:0]                  axi_ar_prot_o,
  output logic [3:0]                  axi_ar_qos_o,
  output logic [3:0]                  axi_ar_region_o,
  output logic [AXI_USER_WIDTH-1:0]   axi_ar_user_o,
  output logic                        axi_ar_valid_o,
  input  logic                        axi_ar_ready_i,
  // R
  output logic                        axi_r_ready_o,
  input  logic                        axi_r_valid_i,
  input  logic [1:0]                  axi_r_resp_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_i,
  input  logic                        axi_r_last_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_r_id_i,
  input  logic [AXI_USER_WIDTH-1:0]   axi_r_user_i
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP
  } state_e;

  state_e                      state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [1:0]                  size_q, size_d;
  logic                        we_q, we_d;
  logic [63:0]                 wdata_q, wdata_d;
  logic [7:0]                  strb_q, strb_d;
  logic                        ar_valid_q, ar_valid_d;
  logic                        aw_valid_q, aw_valid_d;
  logic                        w_valid_q, w_valid_d;
  logic                        resp_valid_q, resp_valid_d;
  logic [63:0]                 rdata_q, rdata_d;
  logic [1:0]                  resp_q, resp_d;
  logic [7:0]                  strb_base;
  logic                        aw_fin, w_fin;

  always_comb begin
    strb_base = 8'h01;
    case (rw_size_i)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // A channel counts as finished once its valid has already dropped or it handshakes now.
  assign aw_fin = !aw_valid_q || axi_aw_ready_i;
  assign w_fin  = !w_valid_q  || axi_w_ready_i;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    ar_valid_d   = ar_valid_q;
    aw_valid_d   = aw_valid_q;
    w_valid_d    = w_valid_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    case (state_q)
      IDLE: begin
        if (rw_valid_i) begin
          addr_d = rw_addr_i;
          size_d = rw_size_i;
          we_d   = rw_we_i;
          if (rw_we_i) begin
            wdata_d    = rw_wdata_i << {rw_addr_i[2:0], 3'b000};
            strb_d     = strb_base << rw_addr_i[2:0];
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            state_d    = WR_REQ;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (axi_ar_ready_i) begin
          ar_valid_d = 1'b0;
          state_d    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (axi_r_valid_i) begin
          rdata_d      = axi_r_data_i >> {addr_q[2:0], 3'b000};
          resp_d       = axi_r_resp_i;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      WR_REQ: begin
        if (aw_valid_q && axi_aw_ready_i) aw_valid_d = 1'b0;
        if (w_valid_q && axi_w_ready_i)   w_valid_d  = 1'b0;
        if (aw_fin && w_fin)              state_d    = WR_RESP;
      end
      WR_RESP: begin
        if (axi_b_valid_i) begin
          resp_d       = axi_b_resp_i;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      ar_valid_q   <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      ar_valid_q   <= ar_valid_d;
      aw_valid_q   <= aw_valid_d;
      w_valid_q    <= w_valid_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign rw_ready_o      = (state_q == IDLE);
  assign rw_resp_valid_o = resp_valid_q;
  assign rw_rdata_o      = rdata_q;
  assign rw_resp_o       = resp_q;

  assign axi_aw_id_o     = '0;
  assign axi_aw_addr_o   = addr_q;
  assign axi_aw_len_o    = '0;
  assign axi_aw_size_o   = {1'b0, size_q};
  assign axi_aw_burst_o  = 2'b01;
  assign axi_aw_lock_o   = 1'b0;
  assign axi_aw_cache_o  = 4'b0010;
  assign axi_aw_prot_o   = 3'b000;
  assign axi_aw_qos_o    = '0;
  assign axi_aw_region_o = '0;
  assign axi_aw_user_o   = '0;
  assign axi_aw_valid_o  = aw_valid_q;

  assign axi_w_data_o    = wdata_q;
  assign axi_w_strb_o    = strb_q;
  assign axi_w_last_o    = w_valid_q;
  assign axi_w_user_o    = '0;
  assign axi_w_valid_o   = w_valid_q;

  assign axi_b_ready_o   = (state_q == WR_RESP);

  assign axi_ar_id_o     = '0;
  assign axi_ar_addr_o   = addr_q;
  assign axi_ar_len_o    = '0;
  assign axi_ar_size_o   = {1'b0, size_q};
  assign axi_ar_burst_o  = 2'b01;
  assign axi_ar_lock_o   = 1'b0;
  assign axi_ar_cache_o  = 4'b0010;
  assign axi_ar_prot_o   = 3'b000;
  assign axi_ar_qos_o    = '0;
  assign axi_ar_region_o = '0;
  assign axi_ar_user_o   = '0;
  assign axi_ar_valid_o  = ar_valid_q;

  assign axi_r_ready_o   = (state_q == RD_DATA);

  logic unused_inputs;
  assign unused_inputs = ^{axi_r_id_i, axi_r_user_i, axi_r_last_i, axi_b_id_i, axi_b_user_i, we_q};

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Directed self-checking bench for axi_rw_bridge: loads, stores, split handshakes, errors, reset abort.
module tb_axi_rw_bridge;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned UW = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rw_valid_i, rw_ready_o, rw_we_i;
  logic [AW-1:0] rw_addr_i;
  logic [1:0]    rw_size_i;
  logic [63:0]   rw_wdata_i;
  logic          rw_resp_valid_o;
  logic [63:0]   rw_rdata_o;
  logic [1:0]    rw_resp_o;

  logic [IW-1:0] aw_id, ar_id;
  logic [AW-1:0] aw_addr, ar_addr;
  logic [7:0]    aw_len, ar_len;
  logic [2:0]    aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]    aw_burst, ar_burst;
  logic          aw_lock, ar_lock;
  logic [3:0]    aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [UW-1:0] aw_user, ar_user, w_user;
  logic          aw_valid, aw_ready, ar_valid, ar_ready;
  logic [DW-1:0] w_data;
  logic [7:0]    w_strb;
  logic          w_last, w_valid, w_ready;
  logic          b_ready, b_valid;
  logic [1:0]    b_resp;
  logic          r_ready, r_valid, r_last;
  logic [1:0]    r_resp;
  logic [DW-1:0] r_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_rw_bridge #(
    .AXI_ADDR_WIDTH(AW),
    .AXI_DATA_WIDTH(DW),
    .AXI_ID_WIDTH(IW),
    .AXI_USER_WIDTH(UW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rw_valid_i(rw_valid_i), .rw_ready_o(rw_ready_o), .rw_we_i(rw_we_i),
    .rw_addr_i(rw_addr_i), .rw_size_i(rw_size_i), .rw_wdata_i(rw_wdata_i),
    .rw_resp_valid_o(rw_resp_valid_o), .rw_rdata_o(rw_rdata_o), .rw_resp_o(rw_resp_o),
    .axi_aw_id_o(aw_id), .axi_aw_addr_o(aw_addr), .axi_aw_len_o(aw_len),
    .axi_aw_size_o(aw_size), .axi_aw_burst_o(aw_burst), .axi_aw_lock_o(aw_lock),
    .axi_aw_cache_o(aw_cache), .axi_aw_prot_o(aw_prot), .axi_aw_qos_o(aw_qos),
    .axi_aw_region_o(aw_region), .axi_aw_user_o(aw_user), .axi_aw_valid_o(aw_valid),
    .axi_aw_ready_i(aw_ready),
    .axi_w_data_o(w_data), .axi_w_strb_o(w_strb), .axi_w_last_o(w_last),
    .axi_w_user_o(w_user), .axi_w_valid_o(w_valid), .axi_w_ready_i(w_ready),
    .axi_b_ready_o(b_ready), .axi_b_valid_i(b_valid), .axi_b_resp_i(b_resp),
    .axi_b_id_i('0), .axi_b_user_i('0),
    .axi_ar_id_o(ar_id), .axi_ar_addr_o(ar_addr), .axi_ar_len_o(ar_len),
    .axi_ar_size_o(ar_size), .axi_ar_burst_o(ar_burst), .axi_ar_lock_o(ar_lock),
    .axi_ar_cache_o(ar_cache), .axi_ar_prot_o(ar_prot), .axi_ar_qos_o(ar_qos),
    .axi_ar_region_o(ar_region), .axi_ar_user_o(ar_user), .axi_ar_valid_o(ar_valid),
    .axi_ar_ready_i(ar_ready),
    .axi_r_ready_o(r_ready), .axi_r_valid_i(r_valid), .axi_r_resp_i(r_resp),
    .axi_r_data_i(r_data), .axi_r_last_i(r_last), .axi_r_id_i('0), .axi_r_user_i('0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata);
    rw_valid_i = 1'b1;
    rw_we_i    = we;
    rw_addr_i  = addr;
    rw_size_i  = size;
    rw_wdata_i = wdata;
  endtask

  initial begin
    rst_n = 1'b0;
    rw_valid_i = 1'b0; rw_we_i = 1'b0; rw_addr_i = '0; rw_size_i = '0; rw_wdata_i = '0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = '0;
    r_valid = 1'b0; r_resp = '0; r_data = '0; r_last = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_rw_ready", 64'(rw_ready_o), 64'd1);
    check("rst_valids", 64'({ar_valid, aw_valid, w_valid, rw_resp_valid_o}), 64'd0);
    check("rst_readies", 64'({r_ready, b_ready}), 64'd0);
    check("rst_rdata", rw_rdata_o, 64'd0);
    check("rst_resp", 64'(rw_resp_o), 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // load double, zero wait: accept c0, AR c1, R c2, pulse c3
    request(1'b0, 64'h8000_0008, 2'd3, '0);
    next_cycle();
    rw_valid_i = 1'b0; ar_ready = 1'b1;
    @(negedge clk);
    check("t1_ar_valid", 64'(ar_valid), 64'd1);
    check("t1_ar_addr", ar_addr, 64'h8000_0008);
    check("t1_ar_size", 64'(ar_size), 64'd3);
    check("t1_ar_len", 64'(ar_len), 64'd0);
    check("t1_ar_burst_cache", 64'({ar_burst, ar_cache}), 64'h12);
    next_cycle();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h1122_3344_5566_7788; r_resp = 2'b00;
    @(negedge clk);
    check("t1_r_ready", 64'(r_ready), 64'd1);
    check("t1_no_early_pulse", 64'(rw_resp_valid_o), 64'd0);
    next_cycle();
    r_valid = 1'b0;
    @(negedge clk);
    check("t1_pulse", 64'(rw_resp_valid_o), 64'd1);
    check("t1_rdata", rw_rdata_o, 64'h1122_3344_5566_7788);
    check("t1_resp", 64'(rw_resp_o), 64'd0);
    check("t1_ready_again", 64'(rw_ready_o), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t1_pulse_one_cycle", 64'(rw_resp_valid_o), 64'd0);
    next_cycle();

    // byte load at offset 5, stray r_valid during RD_ADDR, 4 wait cycles on R
    request(1'b0, 64'h8000_0005, 2'd0, '0);
    next_cycle();
    rw_valid_i = 1'b0; ar_ready = 1'b1; r_valid = 1'b1; r_data = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("t2_r_ready_low_in_ar", 64'(r_ready), 64'd0);
    next_cycle();
    ar_ready = 1'b0; r_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_wait_no_pulse", 64'({r_ready, rw_resp_valid_o}), 64'b10);
      next_cycle();
    end
    r_valid = 1'b1; r_data = 64'h1200_AB00_0000_0000; r_resp = 2'b00;
    next_cycle();
    r_valid = 1'b0;
    @(negedge clk);
    check("t2_pulse", 64'(rw_resp_valid_o), 64'd1);
    check("t2_rdata_byte", 64'(rw_rdata_o[7:0]), 64'hAB);
    check("t2_rdata_full", rw_rdata_o, 64'h0000_0000_0012_00AB);
    next_cycle();

    // half store 0xBEEF at offset 6
    request(1'b1, 64'h8000_0006, 2'd1, 64'h0000_0000_0000_BEEF);
    next_cycle();
    rw_valid_i = 1'b0; aw_ready = 1'b1; w_ready = 1'b1;
    @(negedge clk);
    check("t3_aw_w_valid", 64'({aw_valid, w_valid}), 64'b11);
    check("t3_strb", 64'(w_strb), 64'hC0);
    check("t3_wdata", w_data, 64'hBEEF_0000_0000_0000);
    check("t3_wlast", 64'(w_last), 64'd1);
    check("t3_aw_addr", aw_addr, 64'h8000_0006);
    check("t3_aw_size", 64'(aw_size), 64'd1);
    check("t3_b_ready_low", 64'(b_ready), 64'd0);
    next_cycle();
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
    @(negedge clk);
    check("t3_valids_dropped", 64'({aw_valid, w_valid}), 64'd0);
    check("t3_b_ready", 64'(b_ready), 64'd1);
    next_cycle();
    b_valid = 1'b0;
    @(negedge clk);
    check("t3_pulse", 64'(rw_resp_valid_o), 64'd1);
    check("t3_bresp", 64'(rw_resp_o), 64'd0);
    next_cycle();

    // word store, W accepted at once, AW three cycles later
    request(1'b1, 64'h8000_0004, 2'd2, 64'h0000_0000_DEAD_BEEF);
    next_cycle();
    rw_valid_i = 1'b0; w_ready = 1'b1;
    @(negedge clk);
    check("t4_strb", 64'(w_strb), 64'hF0);
    check("t4_wdata", w_data, 64'hDEAD_BEEF_0000_0000);
    next_cycle();
    w_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("t4_split_hold", 64'({aw_valid, w_valid, b_ready}), 64'b100);
      next_cycle();
    end
    aw_ready = 1'b1;
    @(negedge clk);
    check("t4_aw_last_wait", 64'({aw_valid, w_valid, b_ready}), 64'b100);
    next_cycle();
    aw_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b01;
    @(negedge clk);
    check("t4_b_ready", 64'({aw_valid, w_valid, b_ready}), 64'b001);
    next_cycle();
    b_valid = 1'b0;
    @(negedge clk);
    check("t4_pulse", 64'(rw_resp_valid_o), 64'd1);
    check("t4_bresp", 64'(rw_resp_o), 64'd1);
    check("t4_rdata_held", rw_rdata_o, 64'h0000_0000_0012_00AB);
    next_cycle();

    // word load with SLVERR; request kept valid, second accepted on the pulse cycle
    request(1'b0, 64'h8000_0004, 2'd2, '0);
    next_cycle();
    ar_ready = 1'b1;
    @(negedge clk);
    check("t5_busy_c1", 64'(rw_ready_o), 64'd0);
    next_cycle();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'hCAFE_F00D_1234_5678; r_resp = 2'b10;
    @(negedge clk);
    check("t5_busy_c2", 64'(rw_ready_o), 64'd0);
    next_cycle();
    r_valid = 1'b0;
    @(negedge clk);
    check("t5_pulse", 64'({rw_resp_valid_o, rw_ready_o}), 64'b11);
    check("t5_resp_slverr", 64'(rw_resp_o), 64'h2);
    check("t5_rdata", rw_rdata_o, 64'h0000_0000_CAFE_F00D);
    next_cycle();
    rw_valid_i = 1'b0; ar_ready = 1'b1;
    @(negedge clk);
    check("t5_second_ar", 64'({ar_valid, rw_ready_o}), 64'b10);
    next_cycle();
    ar_ready = 1'b0; r_valid = 1'b1; r_data = 64'h0000_0001_0000_0000; r_resp = 2'b00;
    next_cycle();
    r_valid = 1'b0;
    @(negedge clk);
    check("t5_second_pulse", 64'(rw_resp_valid_o), 64'd1);
    check("t5_second_rdata", rw_rdata_o, 64'd1);
    check("t5_second_resp", 64'(rw_resp_o), 64'd0);
    next_cycle();

    // reset while waiting in RD_DATA
    request(1'b0, 64'h8000_0000, 2'd3, '0);
    next_cycle();
    rw_valid_i = 1'b0; ar_ready = 1'b1;
    next_cycle();
    ar_ready = 1'b0;
    @(negedge clk);
    check("t6_in_rd_data", 64'(r_ready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_abort", 64'({r_ready, rw_ready_o, ar_valid, rw_resp_valid_o}), 64'b0100);
    check("t6_rdata_cleared", rw_rdata_o, 64'd0);
    next_cycle();
    rst_n = 1'b1; r_valid = 1'b1; r_data = 64'h5555_5555_5555_5555;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_pulse", 64'({rw_resp_valid_o, r_ready, rw_ready_o}), 64'b001);
      next_cycle();
    end
    r_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
